// File: rtl/midi_msg_framer.sv
// midi_msg_framer: turns one MIDI channel-voice request into status/d1/d2 bytes
// and hands them to the UART one at a time over its send/ready handshake.
// Optional running-status mode drops a status byte that repeats the previous one.
module midi_msg_framer #(
   parameter logic [3:0] CHANNEL        = 4'd0,
   parameter bit         RUNNING_STATUS = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_cmd,
   input  logic [6:0] req_d1,
   input  logic [6:0] req_d2,
   output logic       req_ready,
   output logic [7:0] tx_data,
   output logic       tx_send,
   input  logic       tx_ready,
   output logic       msg_done,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_t;

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] status_q, status_d;
   logic [6:0] d1_q, d1_d;
   logic [6:0] d2_q, d2_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [7:0] last_status_q, last_status_d;
   logic       msg_done_q, msg_done_d;
   logic [3:0] type_nib;
   logic [7:0] req_status;

   // Map the 2-bit request code onto the MIDI status high nibble.
   always_comb begin
      type_nib = 4'h8;
      case (req_cmd)
         2'd0:    type_nib = 4'h8;
         2'd1:    type_nib = 4'h9;
         2'd2:    type_nib = 4'hB;
         default: type_nib = 4'hE;
      endcase
      req_status = {type_nib, CHANNEL};
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign tx_send   = (state_q == S_SEND) && tx_ready;
   assign tx_data   = tx_data_q;
   assign msg_done  = msg_done_q;

   // Next-state logic: byte sequencing, GUARD spacer and running-status tracking.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      status_d      = status_q;
      d1_d          = d1_q;
      d2_d          = d2_q;
      tx_data_d     = tx_data_q;
      last_status_d = last_status_q;
      msg_done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               status_d = req_status;
               d1_d     = req_d1;
               d2_d     = req_d2;
               state_d  = S_SEND;
               if (RUNNING_STATUS && (req_status == last_status_q)) begin
                  idx_d     = 2'd1;
                  tx_data_d = {1'b0, req_d1};
               end else begin
                  idx_d     = 2'd0;
                  tx_data_d = req_status;
               end
            end
         end
         S_SEND: begin
            if (tx_ready) begin
               state_d = S_GUARD;
               if (idx_q == 2'd0) last_status_d = status_q;
               if (idx_q == 2'd2) msg_done_d = 1'b1;
            end
         end
         // The UART still shows ready on the cycle after a send; skip it.
         S_GUARD: state_d = S_WAIT;
         default: begin
            if (tx_ready) begin
               if (idx_q == 2'd2) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d     = idx_q + 2'd1;
                  state_d   = S_SEND;
                  tx_data_d = (idx_q == 2'd0) ? {1'b0, d1_q} : {1'b0, d2_q};
               end
            end
         end
      endcase
   end

   // Control registers, cleared by reset (abandons any message in flight).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= 2'd0;
         tx_data_q     <= 8'h00;
         last_status_q <= 8'h00;
         msg_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         tx_data_q     <= tx_data_d;
         last_status_q <= last_status_d;
         msg_done_q    <= msg_done_d;
      end
   end

   // Latched request payload; only meaningful while a message is in flight.
   always_ff @(posedge clk) begin
      status_q <= status_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
   end

endmodule

// File: tb/tb_midi_msg_framer.sv
// Bench for midi_msg_framer: three instances (ch0, ch5, ch0+running status),
// each fed by a UART model whose ready drops after a send and returns 20 cycles later.
module tb_midi_msg_framer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req_valid, req_ready, tx_send, msg_done, busy;
   logic [2:0] tx_ready = 3'b111;
   logic [2:0] hold = 3'b000;
   logic [1:0] req_cmd[3];
   logic [6:0] req_d1[3];
   logic [6:0] req_d2[3];
   logic [7:0] tx_data[3];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ucnt[3];
   int last_send[3];
   int sent_cnt[3];
   int done_cnt[3];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];

   always #5 clk = ~clk;

   midi_msg_framer #(.CHANNEL(4'd0), .RUNNING_STATUS(1'b0)) u_ch0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_cmd(req_cmd[0]),
      .req_d1(req_d1[0]), .req_d2(req_d2[0]), .req_ready(req_ready[0]),
      .tx_data(tx_data[0]), .tx_send(tx_send[0]), .tx_ready(tx_ready[0]),
      .msg_done(msg_done[0]), .busy(busy[0]));

   midi_msg_framer #(.CHANNEL(4'd5), .RUNNING_STATUS(1'b0)) u_ch5 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_cmd(req_cmd[1]),
      .req_d1(req_d1[1]), .req_d2(req_d2[1]), .req_ready(req_ready[1]),
      .tx_data(tx_data[1]), .tx_send(tx_send[1]), .tx_ready(tx_ready[1]),
      .msg_done(msg_done[1]), .busy(busy[1]));

   midi_msg_framer #(.CHANNEL(4'd0), .RUNNING_STATUS(1'b1)) u_rs (
      .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_cmd(req_cmd[2]),
      .req_d1(req_d1[2]), .req_d2(req_d2[2]), .req_ready(req_ready[2]),
      .tx_data(tx_data[2]), .tx_send(tx_send[2]), .tx_ready(tx_ready[2]),
      .msg_done(msg_done[2]), .busy(busy[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int i, input logic [7:0] b);
      case (i)
         0:       q0.push_back(b);
         1:       q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endtask

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic pop_exp(input int i, output bit ok, output logic [7:0] b);
      ok = (qsize(i) != 0);
      b  = 8'h00;
      if (ok) begin
         case (i)
            0:       b = q0.pop_front();
            1:       b = q1.pop_front();
            default: b = q2.pop_front();
         endcase
      end
   endtask

   // UART model: ready drops the cycle after a send and comes back 20 cycles later.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            tx_ready[i] <= 1'b1;
            ucnt[i]     <= 0;
         end else if (hold[i]) begin
            tx_ready[i] <= 1'b0;
            ucnt[i]     <= 0;
         end else if (tx_send[i]) begin
            tx_ready[i] <= 1'b0;
            ucnt[i]     <= 20;
         end else if (ucnt[i] > 1) begin
            ucnt[i]     <= ucnt[i] - 1;
         end else begin
            ucnt[i]     <= 0;
            tx_ready[i] <= 1'b1;
         end
      end
   end

   // Scoreboard monitor: every send pops one expected byte; sends must be >=3 cycles apart.
   always @(negedge clk) begin
      bit         ok;
      logic [7:0] b;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (tx_send[i] === 1'b1) begin
            pop_exp(i, ok, b);
            if (!ok) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_send inst%0d: got 0x%0h, required no send", i, tx_data[i]);
            end else begin
               check($sformatf("tx_byte inst%0d", i), {24'd0, tx_data[i]}, {24'd0, b});
            end
            if (sent_cnt[i] > 0)
               check($sformatf("send_spacing_ok inst%0d", i), {31'd0, (cyc - last_send[i]) >= 3}, 32'd1);
            last_send[i] = cyc;
            sent_cnt[i]++;
         end
         if (msg_done[i] === 1'b1) done_cnt[i]++;
      end
   end

   task automatic wait_ready(input int i);
      for (int k = 0; k < 300 && req_ready[i] !== 1'b1; k++) @(negedge clk);
      check($sformatf("req_ready inst%0d", i), {31'd0, req_ready[i]}, 32'd1);
   endtask

   task automatic drive_req(input int i, input logic [1:0] cmd, input logic [6:0] d1, input logic [6:0] d2);
      wait_ready(i);
      req_cmd[i]   = cmd;
      req_d1[i]    = d1;
      req_d2[i]    = d2;
      req_valid[i] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int target);
      int k = 0;
      while (done_cnt[i] < target && k < 400) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("msg_done_count inst%0d", i), done_cnt[i], target);
   endtask

   task automatic finish_msg(input int i, input int target);
      wait_done(i, target);
      check($sformatf("queue_drained inst%0d", i), qsize(i), 0);
      wait_ready(i);
      @(negedge clk);
      check($sformatf("busy_idle inst%0d", i), {31'd0, busy[i]}, 32'd0);
      check($sformatf("msg_done_once inst%0d", i), done_cnt[i], target);
   endtask

   typedef struct {
      int         inst;
      logic [1:0] cmd;
      logic [6:0] d1;
      logic [6:0] d2;
      int         nb;
      logic [7:0] b0, b1, b2;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int s0;
      // inst, cmd, d1, d2, byte count, expected bytes in order
      tbl[0] = '{0, 2'd1, 7'd60,  7'd100, 3, 8'h90, 8'h3C, 8'h64};
      tbl[1] = '{1, 2'd3, 7'h00,  7'h40,  3, 8'hE5, 8'h00, 8'h40};
      tbl[2] = '{2, 2'd1, 7'd60,  7'd100, 3, 8'h90, 8'h3C, 8'h64};
      tbl[3] = '{2, 2'd1, 7'd62,  7'd90,  2, 8'h3E, 8'h5A, 8'h00};
      tbl[4] = '{2, 2'd2, 7'd7,   7'd127, 3, 8'hB0, 8'h07, 8'h7F};
      tbl[5] = '{0, 2'd0, 7'd64,  7'd0,   3, 8'h80, 8'h40, 8'h00};
      tbl[6] = '{0, 2'd1, 7'h7F,  7'd0,   3, 8'h90, 8'h7F, 8'h00};
      tbl[7] = '{1, 2'd2, 7'd1,   7'd2,   3, 8'hB5, 8'h01, 8'h02};
      tbl[8] = '{0, 2'd1, 7'd60,  7'd100, 3, 8'h90, 8'h3C, 8'h64};

      req_valid = 3'b000;
      for (int i = 0; i < 3; i++) begin
         req_cmd[i] = 2'd0; req_d1[i] = 7'd0; req_d2[i] = 7'd0;
         ucnt[i] = 0; last_send[i] = 0; sent_cnt[i] = 0; done_cnt[i] = 0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_req_ready inst%0d", i), {31'd0, req_ready[i]}, 32'd1);
         check($sformatf("rst_tx_send inst%0d", i),   {31'd0, tx_send[i]},   32'd0);
         check($sformatf("rst_tx_data inst%0d", i),   {24'd0, tx_data[i]},   32'd0);
         check($sformatf("rst_msg_done inst%0d", i),  {31'd0, msg_done[i]},  32'd0);
         check($sformatf("rst_busy inst%0d", i),      {31'd0, busy[i]},      32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Table-driven single messages.
      for (int v = 0; v < 9; v++) begin
         int i;
         i  = tbl[v].inst;
         d0 = done_cnt[i];
         push_exp(i, tbl[v].b0);
         push_exp(i, tbl[v].b1);
         if (tbl[v].nb == 3) push_exp(i, tbl[v].b2);
         drive_req(i, tbl[v].cmd, tbl[v].d1, tbl[v].d2);
         check($sformatf("first_send_latency vec%0d", v), {31'd0, tx_send[i]}, 32'd1);
         finish_msg(i, d0 + 1);
      end

      // UART stalled for 50 cycles while a byte is pending in SEND.
      @(negedge clk);
      hold[0] = 1'b1;
      d0 = done_cnt[0];
      push_exp(0, 8'h90); push_exp(0, 8'h11); push_exp(0, 8'h22);
      drive_req(0, 2'd1, 7'h11, 7'h22);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         check("stall_no_send", {31'd0, tx_send[0]}, 32'd0);
         check("stall_tx_data", {24'd0, tx_data[0]}, 32'h90);
         check("stall_busy", {31'd0, busy[0]}, 32'd1);
      end
      hold[0] = 1'b0;
      finish_msg(0, d0 + 1);

      // Reset after the first byte of a note-off; the retry must carry its status byte.
      s0 = sent_cnt[2];
      push_exp(2, 8'h80);
      drive_req(2, 2'd0, 7'd64, 7'd0);
      for (int k = 0; k < 100 && sent_cnt[2] == s0; k++) @(negedge clk);
      check("midmsg_first_byte_sent", sent_cnt[2], s0 + 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midmsg_rst_tx_send", {31'd0, tx_send[2]}, 32'd0);
      check("midmsg_rst_req_ready", {31'd0, req_ready[2]}, 32'd1);
      check("midmsg_rst_busy", {31'd0, busy[2]}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("midmsg_queue", qsize(2), 0);
      d0 = done_cnt[2];
      push_exp(2, 8'h80); push_exp(2, 8'h40); push_exp(2, 8'h00);
      drive_req(2, 2'd0, 7'd64, 7'd0);
      finish_msg(2, d0 + 1);

      // req_valid held high across three back-to-back CCs.
      d0 = done_cnt[0];
      s0 = sent_cnt[0];
      for (int k = 0; k < 3; k++) begin
         push_exp(0, 8'hB0);
         push_exp(0, 8'h0A + 8'(k));
         push_exp(0, 8'h01 + 8'(k));
      end
      for (int k = 0; k < 3; k++) begin
         req_cmd[0]   = 2'd2;
         req_d1[0]    = 7'h0A + 7'(k);
         req_d2[0]    = 7'h01 + 7'(k);
         req_valid[0] = 1'b1;
         wait_ready(0);
         @(posedge clk);
         #1;
      end
      req_valid[0] = 1'b0;
      finish_msg(0, d0 + 3);
      check("held_valid_send_count", sent_cnt[0] - s0, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
